ltc5548_sys_pio_arbiter: RTL and testbench
==========================================

// Module: ltc5548_sys_pio_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one 1-bit Avalon-MM PIO output (LTC5548 control line) among NUM_REQ requesters.
//  Each requester asks for WRITE/SET/CLEAR; the block issues single-cycle PIO writes (addr 0/4/5) and enforces a settle gap.
//  Keeps a shadow copy of the PIO output state; sits between control FSMs and the PIO slave in ltc5548_sys.
// PARAMETERS
//  NUM_REQ     4   number of requesters (2..8)
//  GAP_CYCLES  8   idle cycles forced after each bus write (0..255) for LTC5548 settle
//  DATA_W      32  PIO writedata width
// PORTS
//  clk            in   1          system clock
//  reset          in   1          synchronous, active-high reset
//  req_valid      in   NUM_REQ    per-requester request
//  req_op         in   2*NUM_REQ  op per requester [2i+1:2i]: 00 WRITE, 01 SET, 10 CLEAR, 11 reserved
//  req_data       in   NUM_REQ    value for WRITE (bit i per requester)
//  req_ready      out  NUM_REQ    one-hot accept pulse; transfer = valid & ready
//  pio_address    out  3          PIO address (0 data, 4 set, 5 clear)
//  pio_chipselect out  1          PIO chipselect
//  pio_write_n    out  1          PIO write strobe, active low
//  pio_writedata  out  DATA_W     PIO write data
//  shadow_out     out  1          mirror of PIO out_port after accepted writes
//  busy           out  1          high in ISSUE or GAP
//  err_pulse      out  1          1-cycle pulse when reserved op accepted
// BEHAVIOUR
//  Reset (sync): state=IDLE, rr_ptr=0, gap_cnt=0, req_ready=0, pio_chipselect=0, pio_write_n=1,
//   pio_address=0, pio_writedata=0, shadow_out=0, busy=0, err_pulse=0. Matches PIO reset value 0.
//  FSM: IDLE -> ISSUE -> GAP -> IDLE.
//   IDLE: if any req_valid, pick first valid at/after rr_ptr (wrapping NUM_REQ-1 -> 0); latch grant index; -> ISSUE.
//    No valid: stay IDLE.
//   ISSUE (exactly 1 cycle): req_ready[grant]=1; op/data sampled from granted requester this cycle.
//    WRITE: addr=0, wdata={0,req_data}, shadow<=req_data.
//    SET:   addr=4, wdata={0,1'b1}, shadow<=1.  CLEAR: addr=5, wdata={0,1'b1}, shadow<=0.
//    chipselect=1, write_n=0 for this cycle only (PIO has no waitrequest).
//    Reserved 11: request acked, no bus write (chipselect=0), err_pulse=1, shadow unchanged, next -> IDLE (no gap).
//    rr_ptr <= grant+1 (mod NUM_REQ). Next: GAP if GAP_CYCLES>0 else IDLE.
//   GAP: gap_cnt counts GAP_CYCLES cycles (load GAP_CYCLES-1, decrement to 0), then -> IDLE. Requests ignored.
//  Outputs registered; bus signals default to idle values outside ISSUE.
//  Latency: valid seen at IDLE edge n -> write strobe and req_ready in cycle n+1.
//  Throughput: one write per GAP_CYCLES+2 cycles, fair over all continuously active requesters.
//  Requesters hold valid/op/data stable until ready; dropping valid before ready is illegal (asserted in sim).
//  Simultaneous requests: round-robin only; no priority. Single requester repeating: served every GAP_CYCLES+2.
//  Reset mid-ISSUE or mid-GAP: strobe drops at that edge, no partial write, pending grant discarded.
// TESTING
//  T1 reset: hold reset 3 cycles with all req_valid=1 -> no strobes, req_ready=0, shadow_out=0, busy=0.
//  T2 single WRITE: req0 op=00 data=1, GAP=8 -> cycle+1 addr=0 wdata=1 write_n=0, ready[0]=1, shadow=1, busy 9 cycles.
//  T3 round-robin: req0..3 all SET held -> grants 0,1,2,3,0 exactly 10 cycles apart; addr=4 each.
//  T4 SET then CLEAR: req1 SET, req2 CLEAR -> addr 4 then 5, wdata=1 both, shadow 1 then 0; PIO model agrees.
//  T5 reserved op: req3 op=11 -> ready[3]=1, err_pulse=1, chipselect stays 0, next grant 2 cycles later.
//  T6 reset in GAP: reset asserted at gap_cnt=4 -> next cycle IDLE, rr_ptr=0, shadow=0; GAP_CYCLES=0 build gives 2-cycle spacing.

Source files
------------

// File: rtl/ltc5548_sys_pio_arbiter.sv
// Round-robin sequencer sharing one LTC5548 PIO control line among NUM_REQ requesters.
// Issues single-cycle Avalon-MM writes (data/set/clear), then holds the bus idle for a settle gap.
module ltc5548_sys_pio_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 8,
    parameter int DATA_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [2*NUM_REQ-1:0] req_op,
    input  logic [NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [2:0]           pio_address,
    output logic                 pio_chipselect,
    output logic                 pio_write_n,
    output logic [DATA_W-1:0]    pio_writedata,
    output logic                 shadow_out,
    output logic                 busy,
    output logic                 err_pulse
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [7:0]          gap_cnt_q, gap_cnt_d;
    logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
    logic [2:0]          pio_address_q, pio_address_d;
    logic                pio_chipselect_q, pio_chipselect_d;
    logic                pio_write_n_q, pio_write_n_d;
    logic [DATA_W-1:0]   pio_writedata_q, pio_writedata_d;
    logic                shadow_q, shadow_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic [IDX_W-1:0]    cand;
    logic [IDX_W-1:0]    win;
    logic                found;
    logic [IDX_W-1:0]    sel_idx;
    logic [1:0]          sel_op;
    logic                sel_data;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (int'(idx) >= NUM_REQ - 1)
            return '0;
        return idx + IDX_W'(1);
    endfunction

    always_comb begin
        state_d          = state_q;
        rr_ptr_d         = rr_ptr_q;
        grant_d          = grant_q;
        gap_cnt_d        = gap_cnt_q;
        req_ready_d      = '0;
        pio_address_d    = 3'd0;
        pio_chipselect_d = 1'b0;
        pio_write_n_d    = 1'b1;
        pio_writedata_d  = '0;
        shadow_d         = shadow_q;
        err_d            = 1'b0;

        // First valid requester at or after the round-robin pointer, wrapping.
        found = 1'b0;
        win   = rr_ptr_q;
        cand  = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
            cand = next_idx(cand);
        end

        sel_idx  = (state_q == IDLE) ? win : grant_q;
        sel_op   = req_op[{sel_idx, 1'b0} +: 2];
        sel_data = req_data[sel_idx];

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d          = win;
                    state_d          = ISSUE;
                    req_ready_d[win] = 1'b1;
                    case (sel_op)
                        OP_WRITE: begin
                            pio_chipselect_d   = 1'b1;
                            pio_write_n_d      = 1'b0;
                            pio_address_d      = 3'd0;
                            pio_writedata_d[0] = sel_data;
                        end
                        OP_SET: begin
                            pio_chipselect_d   = 1'b1;
                            pio_write_n_d      = 1'b0;
                            pio_address_d      = 3'd4;
                            pio_writedata_d[0] = 1'b1;
                        end
                        OP_CLEAR: begin
                            pio_chipselect_d   = 1'b1;
                            pio_write_n_d      = 1'b0;
                            pio_address_d      = 3'd5;
                            pio_writedata_d[0] = 1'b1;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ISSUE: begin
                rr_ptr_d = next_idx(grant_q);
                case (sel_op)
                    OP_WRITE: shadow_d = sel_data;
                    OP_SET:   shadow_d = 1'b1;
                    OP_CLEAR: shadow_d = 1'b0;
                    default:  shadow_d = shadow_q;
                endcase
                // A reserved op never touched the bus, so no settle time is owed.
                if (GAP_CYCLES == 0 || sel_op == 2'b11) begin
                    state_d = IDLE;
                end else begin
                    state_d   = GAP;
                    gap_cnt_d = 8'(GAP_CYCLES - 1);
                end
            end
            GAP: begin
                if (gap_cnt_q == 8'd0)
                    state_d = IDLE;
                else
                    gap_cnt_d = gap_cnt_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            rr_ptr_q         <= '0;
            grant_q          <= '0;
            gap_cnt_q        <= 8'd0;
            req_ready_q      <= '0;
            pio_address_q    <= 3'd0;
            pio_chipselect_q <= 1'b0;
            pio_write_n_q    <= 1'b1;
            pio_writedata_q  <= '0;
            shadow_q         <= 1'b0;
            busy_q           <= 1'b0;
            err_q            <= 1'b0;
        end else begin
            state_q          <= state_d;
            rr_ptr_q         <= rr_ptr_d;
            grant_q          <= grant_d;
            gap_cnt_q        <= gap_cnt_d;
            req_ready_q      <= req_ready_d;
            pio_address_q    <= pio_address_d;
            pio_chipselect_q <= pio_chipselect_d;
            pio_write_n_q    <= pio_write_n_d;
            pio_writedata_q  <= pio_writedata_d;
            shadow_q         <= shadow_d;
            busy_q           <= busy_d;
            err_q            <= err_d;
        end
    end

    // A granted requester must keep its request up until the accept pulse completes.
    always_ff @(posedge clk) begin
        if (!reset && state_q == ISSUE)
            assert (req_valid[grant_q]) else $error("requester dropped valid before ready");
    end

    assign req_ready      = req_ready_q;
    assign pio_address    = pio_address_q;
    assign pio_chipselect = pio_chipselect_q;
    assign pio_write_n    = pio_write_n_q;
    assign pio_writedata  = pio_writedata_q;
    assign shadow_out     = shadow_q;
    assign busy           = busy_q;
    assign err_pulse      = err_q;

endmodule

// File: tb/tb_ltc5548_sys_pio_arbiter.sv
// Scoreboard bench for ltc5548_sys_pio_arbiter: directed requests queue expected grants,
// a monitor checks each accept pulse against the queue and an Avalon PIO register model.
`timescale 1ns/1ps
module tb_ltc5548_sys_pio_arbiter;
    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [2*NR-1:0] req_op = '0;
    logic [NR-1:0]   req_data = '0;
    logic [NR-1:0]   req_ready;
    logic [2:0]      pio_address;
    logic            pio_chipselect, pio_write_n;
    logic [31:0]     pio_writedata;
    logic            shadow_out, busy, err_pulse;

    logic [NR-1:0]   g0_valid = '0;
    logic [2*NR-1:0] g0_op = '0;
    logic [NR-1:0]   g0_data = '0;
    logic [NR-1:0]   g0_ready;
    logic [2:0]      g0_address;
    logic            g0_cs, g0_write_n;
    logic [31:0]     g0_writedata;
    logic            g0_shadow, g0_busy, g0_err;

    always #5 clk = ~clk;

    ltc5548_sys_pio_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(8), .DATA_W(32)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
        .req_ready(req_ready), .pio_address(pio_address), .pio_chipselect(pio_chipselect),
        .pio_write_n(pio_write_n), .pio_writedata(pio_writedata), .shadow_out(shadow_out),
        .busy(busy), .err_pulse(err_pulse)
    );

    ltc5548_sys_pio_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(0), .DATA_W(32)) u_dut_g0 (
        .clk(clk), .reset(reset), .req_valid(g0_valid), .req_op(g0_op), .req_data(g0_data),
        .req_ready(g0_ready), .pio_address(g0_address), .pio_chipselect(g0_cs),
        .pio_write_n(g0_write_n), .pio_writedata(g0_writedata), .shadow_out(g0_shadow),
        .busy(g0_busy), .err_pulse(g0_err)
    );

    typedef struct {
        int       who;
        bit       cs;
        bit [2:0] addr;
        bit       wd;
        bit       err;
        bit       shadow;
        int       gap;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_cyc = 0;
    int          remaining [NR] = '{default: 0};
    logic [NR-1:0] done_m;
    logic        pio_q;
    bit          mon_en = 1'b0;
    bit          shadow_chk = 1'b0;
    logic        shadow_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int who, input bit cs, input bit [2:0] addr, input bit wd,
                        input bit err, input bit sh, input int gap);
        exp_t e;
        e.who = who; e.cs = cs; e.addr = addr; e.wd = wd; e.err = err; e.shadow = sh; e.gap = gap;
        sbq.push_back(e);
    endtask

    task automatic issue(input int i, input logic [1:0] op, input logic d, input int cnt);
        req_op[2*i +: 2] = op;
        req_data[i]      = d;
        remaining[i]     = cnt;
        req_valid[i]     = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((sbq.size() != 0 || busy !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(sbq.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    always @(posedge clk) cyc++;

    // Requesters hold valid/op/data until their accept pulse, then drop when no repeats remain.
    always @(posedge clk) begin
        done_m = req_ready & req_valid;
        #1;
        for (int i = 0; i < NR; i++) begin
            if (done_m[i] === 1'b1) begin
                remaining[i]--;
                if (remaining[i] <= 0) req_valid[i] = 1'b0;
            end
        end
    end

    // Avalon PIO output register: data at 0, bit-set at 4, bit-clear at 5.
    always @(posedge clk) begin
        if (reset)
            pio_q <= 1'b0;
        else if (pio_chipselect === 1'b1 && pio_write_n === 1'b0) begin
            case (pio_address)
                3'd0: pio_q <= pio_writedata[0];
                3'd4: if (pio_writedata[0]) pio_q <= 1'b1;
                3'd5: if (pio_writedata[0]) pio_q <= 1'b0;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (shadow_chk) begin
                chk("shadow", 64'(shadow_out), 64'(shadow_exp));
                chk("shadow_vs_pio", 64'(shadow_out), 64'(pio_q));
                shadow_chk = 1'b0;
            end
            if (req_ready !== '0) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_grant", 64'(req_ready), 64'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("grant", 64'(req_ready), 64'd1 << mon_e.who);
                    chk("chipselect", 64'(pio_chipselect), 64'(mon_e.cs));
                    chk("write_n", 64'(pio_write_n), 64'(!mon_e.cs));
                    chk("err_pulse", 64'(err_pulse), 64'(mon_e.err));
                    chk("writedata", 64'(pio_writedata), mon_e.cs ? 64'(mon_e.wd) : 64'd0);
                    if (mon_e.cs) chk("address", 64'(pio_address), 64'(mon_e.addr));
                    if (mon_e.gap >= 0) chk("spacing", 64'(cyc - last_cyc), 64'(mon_e.gap));
                    last_cyc   = cyc;
                    shadow_chk = 1'b1;
                    shadow_exp = mon_e.shadow;
                end
            end else begin
                chk("idle_bus", {61'd0, pio_chipselect, pio_write_n, err_pulse}, 64'b010);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pulses;
        int g_last;

        // T1: reset held with every requester active
        req_valid = '1;
        req_data  = '1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("t1_ready", 64'(req_ready), 64'd0);
            chk("t1_cs", 64'(pio_chipselect), 64'd0);
            chk("t1_write_n", 64'(pio_write_n), 64'd1);
            chk("t1_shadow", 64'(shadow_out), 64'd0);
            chk("t1_busy", 64'(busy), 64'd0);
        end
        req_valid = '0;
        req_data  = '0;
        reset     = 1'b0;
        mon_en    = 1'b1;

        // T2: single WRITE of 1 from requester 0
        @(negedge clk);
        issue(0, 2'b00, 1'b1, 1);
        push(0, 1, 3'd0, 1, 0, 1, -1);
        @(negedge clk);
        chk("t2_latency", 64'(req_ready), 64'b0001);
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("t2_busy_cycles", 64'(n), 64'd9);
        wait_idle(40);

        // T3: all four SET held; requester 0 asks twice
        do_reset();
        issue(0, 2'b01, 1'b0, 2);
        issue(1, 2'b01, 1'b0, 1);
        issue(2, 2'b01, 1'b0, 1);
        issue(3, 2'b01, 1'b0, 1);
        push(0, 1, 3'd4, 1, 0, 1, -1);
        push(1, 1, 3'd4, 1, 0, 1, 10);
        push(2, 1, 3'd4, 1, 0, 1, 10);
        push(3, 1, 3'd4, 1, 0, 1, 10);
        push(0, 1, 3'd4, 1, 0, 1, 10);
        wait_idle(80);

        // T4: SET from 1 then CLEAR from 2 (pointer sits at 1)
        issue(1, 2'b01, 1'b0, 1);
        issue(2, 2'b10, 1'b0, 1);
        push(1, 1, 3'd4, 1, 0, 1, -1);
        push(2, 1, 3'd5, 1, 0, 0, 10);
        wait_idle(40);

        // T5: reserved op from 3, then SET from 0 two cycles later
        issue(3, 2'b11, 1'b0, 1);
        issue(0, 2'b01, 1'b0, 1);
        push(3, 0, 3'd0, 0, 1, 0, -1);
        push(0, 1, 3'd4, 1, 0, 1, 2);
        wait_idle(40);

        // T6: reset in the middle of the gap
        issue(2, 2'b00, 1'b1, 1);
        push(2, 1, 3'd0, 1, 0, 1, -1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready[2] !== 1'b1 && n < 20);
        chk("t6_grant_seen", 64'(req_ready[2]), 64'd1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_shadow", 64'(shadow_out), 64'd0);
        chk("t6_cs", 64'(pio_chipselect), 64'd0);
        chk("t6_pio_model", 64'(pio_q), 64'd0);
        reset = 1'b0;
        issue(1, 2'b01, 1'b0, 1);
        issue(3, 2'b01, 1'b0, 1);
        push(1, 1, 3'd4, 1, 0, 1, -1);
        push(3, 1, 3'd4, 1, 0, 1, 10);
        wait_idle(40);

        // Zero-gap build: two requesters held continuously alternate every 2 cycles
        do_reset();
        g0_op    = 8'b01010101;
        g0_valid = 4'b0011;
        pulses = 0;
        g_last = 0;
        n = 0;
        while (pulses < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (g0_ready !== '0) begin
                chk("g0_grant", 64'(g0_ready), (pulses % 2 == 0) ? 64'b0001 : 64'b0010);
                chk("g0_address", 64'(g0_address), 64'd4);
                chk("g0_write_n", 64'(g0_write_n), 64'd0);
                chk("g0_cs", 64'(g0_cs), 64'd1);
                chk("g0_writedata", 64'(g0_writedata), 64'd1);
                chk("g0_busy", 64'(g0_busy), 64'd1);
                chk("g0_err", 64'(g0_err), 64'd0);
                if (pulses > 0) chk("g0_spacing", 64'(cyc - g_last), 64'd2);
                g_last = cyc;
                pulses++;
            end
        end
        chk("g0_pulses", 64'(pulses), 64'd4);
        @(posedge clk);
        #1;
        g0_valid = '0;
        @(negedge clk);
        chk("g0_shadow", 64'(g0_shadow), 64'd1);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
